// File: rtl/adc_pkg.sv
// adc_pkg: shared types and default constants for the ADC sample controller.
package adc_pkg;

    // Controller sequencing states.
    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        WAIT_TICK = 3'd1,
        START     = 3'd2,
        CONVERT   = 3'd3,
        STORE     = 3'd4
    } state_t;

    localparam int DWIDTH_DEFAULT  = 32;
    localparam int DEPTH_DEFAULT   = 8;
    localparam int TIMEOUT_DEFAULT = 64;

    // Interval timer reload: a period of 0 behaves like 1, so the load saturates at 0.
    function automatic logic [15:0] interval_load(input logic [15:0] period);
        return (period == 16'd0) ? 16'd0 : period - 16'd1;
    endfunction

endpackage

// File: rtl/adc_sample_ctrl_if.sv
// adc_sample_ctrl_if: CPU configuration/readout and ADC handshake signals of the sample controller.
interface adc_sample_ctrl_if #(
    parameter int DWIDTH = 32,
    parameter int DEPTH  = 8
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic              enable;
    logic [15:0]       period;
    logic              adc_start;
    logic              adc_done;
    logic [DWIDTH-1:0] adc_raw;
    logic              rd_en;
    logic [DWIDTH-1:0] adcdata;
    logic              sample_valid;
    logic [CW-1:0]     fifo_count;
    logic              overflow;
    logic              timeout_err;
    logic              clr_err;

    // The controller side.
    modport master (
        input  enable, period, adc_done, adc_raw, rd_en, clr_err,
        output adc_start, adcdata, sample_valid, fifo_count, overflow, timeout_err
    );

    // The CPU/ADC environment side.
    modport slave (
        output enable, period, adc_done, adc_raw, rd_en, clr_err,
        input  adc_start, adcdata, sample_valid, fifo_count, overflow, timeout_err
    );

endinterface

// File: rtl/sample_fifo.sv
// sample_fifo: circular sample buffer with occupancy count; a pop frees room for a same-cycle push.
module sample_fifo #(
    parameter int DWIDTH = 32,
    parameter int DEPTH  = 8
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       push,
    input  logic [DWIDTH-1:0]          din,
    input  logic                       pop,
    output logic [DWIDTH-1:0]          dout,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       drop
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [DWIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic              empty;
    logic              full;
    logic              pop_ok;
    logic              push_ok;

    assign empty   = (count == '0);
    assign full    = (count == FULL_CNT);
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);
    assign drop    = push && !push_ok;
    // Head is gated while empty so the read port reads 0 after reset.
    assign dout    = empty ? '0 : mem[rd_ptr];

    // Sample storage: data only, no reset needed.
    always_ff @(posedge clock) begin
        if (push_ok) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers wrap naturally at DEPTH (power of two); count tracks occupancy 0..DEPTH.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/adc_sample_ctrl.sv
// adc_sample_ctrl: paces ADC conversions at a programmable interval, guards each
// conversion with a timeout and queues results for the CPU in sample_fifo.
module adc_sample_ctrl
    import adc_pkg::*;
#(
    parameter int DWIDTH  = DWIDTH_DEFAULT,
    parameter int DEPTH   = DEPTH_DEFAULT,
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic              clock,
    input  logic              reset,
    adc_sample_ctrl_if.master bus
);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0] CONV_LAST = TW'(TIMEOUT - 1);

    state_t            state;
    logic [15:0]       timer;
    logic [TW-1:0]     conv_cnt;
    logic              adc_start_r;
    logic              timeout_r;
    logic              overflow_r;
    logic [DWIDTH-1:0] sample;
    logic              push;
    logic              fifo_drop;
    logic [CW-1:0]     fifo_cnt;
    logic [DWIDTH-1:0] fifo_dout;

    assign push = (state == STORE);

    // Sequencer: interval wait, start pulse, conversion watchdog, store.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            timer       <= '0;
            conv_cnt    <= '0;
            adc_start_r <= 1'b0;
            timeout_r   <= 1'b0;
        end else begin
            adc_start_r <= 1'b0;
            // A timeout in this same clock overrides the clear below.
            if (bus.clr_err) begin
                timeout_r <= 1'b0;
            end
            case (state)
                IDLE: begin
                    if (bus.enable) begin
                        timer <= interval_load(bus.period);
                        state <= WAIT_TICK;
                    end
                end
                WAIT_TICK: begin
                    if (!bus.enable) begin
                        state <= IDLE;
                    end else if (timer == 16'd0) begin
                        adc_start_r <= 1'b1;
                        state       <= START;
                    end else begin
                        timer <= timer - 16'd1;
                    end
                end
                START: begin
                    conv_cnt <= '0;
                    state    <= CONVERT;
                end
                CONVERT: begin
                    if (bus.adc_done) begin
                        state <= STORE;
                    end else if (conv_cnt == CONV_LAST) begin
                        timeout_r <= 1'b1;
                        timer     <= interval_load(bus.period);
                        state     <= WAIT_TICK;
                    end else begin
                        conv_cnt <= conv_cnt + 1'b1;
                    end
                end
                STORE: begin
                    timer <= interval_load(bus.period);
                    state <= bus.enable ? WAIT_TICK : IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Capture the conversion result; only meaningful while converting.
    always_ff @(posedge clock) begin
        if (state == CONVERT && bus.adc_done) begin
            sample <= bus.adc_raw;
        end
    end

    // Sticky overflow flag; a drop in the same clock wins over the clear.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            overflow_r <= 1'b0;
        end else if (fifo_drop) begin
            overflow_r <= 1'b1;
        end else if (bus.clr_err) begin
            overflow_r <= 1'b0;
        end
    end

    sample_fifo #(
        .DWIDTH (DWIDTH),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clock (clock),
        .reset (reset),
        .push  (push),
        .din   (sample),
        .pop   (bus.rd_en),
        .dout  (fifo_dout),
        .count (fifo_cnt),
        .drop  (fifo_drop)
    );

    assign bus.adc_start    = adc_start_r;
    assign bus.adcdata      = fifo_dout;
    assign bus.fifo_count   = fifo_cnt;
    assign bus.sample_valid = (fifo_cnt != '0);
    assign bus.overflow     = overflow_r;
    assign bus.timeout_err  = timeout_r;

endmodule

// File: doc/adc_sample_ctrl.md
ADC_SAMPLE_CTRL -- requirements
Module: adc_sample_ctrl

Interface
REQ-001 Parameter DWIDTH, default 32, sample word width.
REQ-002 Parameter DEPTH, default 8, sample FIFO depth (power of two, >=2).
REQ-003 Parameter TIMEOUT, default 64, max clocks allowed for one conversion.
REQ-004 clock  input  1  single clock; all state on rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 enable  input  1  sampling enable from CPU config register.
REQ-007 period  input  16  sample interval in clocks; 0 treated as 1.
REQ-008 adc_start  output  1  one-cycle conversion-start pulse to ADC.
REQ-009 adc_done  input  1  one-cycle conversion-complete pulse from ADC.
REQ-010 adc_raw  input  DWIDTH  conversion result, valid when adc_done=1.
REQ-011 rd_en  input  1  CPU pop of head sample.
REQ-012 adcdata  output  DWIDTH  head-of-FIFO sample presented to CPU.
REQ-013 sample_valid  output  1  FIFO non-empty.
REQ-014 fifo_count  output  $clog2(DEPTH)+1  current occupancy.
REQ-015 overflow  output  1  sticky: sample dropped because FIFO was full.
REQ-016 timeout_err  output  1  sticky: conversion exceeded TIMEOUT.
REQ-017 clr_err  input  1  clears overflow and timeout_err.

Function
REQ-018 FSM states IDLE, WAIT_TICK, START, CONVERT, STORE.
REQ-019 IDLE -> WAIT_TICK when enable=1; interval timer loads max(period,1)-1.
REQ-020 WAIT_TICK: timer decrements each clock; at 0 -> START; enable=0 -> IDLE.
REQ-021 START: adc_start=1 for exactly one clock, conversion counter cleared, -> CONVERT.
REQ-022 CONVERT: adc_done=1 captures adc_raw and -> STORE; counter reaching TIMEOUT sets timeout_err, -> WAIT_TICK with no push.
REQ-023 STORE: push captured sample, reload timer, -> WAIT_TICK if enable=1 else IDLE.
REQ-024 enable deasserted in START/CONVERT: conversion completes and is stored before IDLE.
REQ-025 Sample interval start-to-start = max(period,1)+conversion latency+2 clocks.
REQ-026 adc_done outside CONVERT is ignored.
REQ-027 adcdata shows head sample combinationally from FIFO storage; sample_valid = (fifo_count != 0).
REQ-028 rd_en with sample_valid=1 pops on that edge; rd_en when empty ignored, count stays 0.
REQ-029 Push when full without same-cycle pop: sample discarded, FIFO unchanged, overflow set.
REQ-030 Push and pop in the same clock when full: both succeed, count unchanged, no overflow.
REQ-031 Push and pop in the same clock when empty: pop ignored, count becomes 1.
REQ-032 Pointers wrap modulo DEPTH; fifo_count range 0..DEPTH.
REQ-033 clr_err clears sticky flags; a set event in the same clock takes priority.

Reset
REQ-034 reset=0 asynchronously forces IDLE, timers 0, FIFO empty, adc_start=0, sample_valid=0, fifo_count=0, overflow=0, timeout_err=0, adcdata=0.
REQ-035 Reset asserted mid-conversion abandons it; a later adc_done is ignored as per REQ-026.

Structure
REQ-036 Package adc_pkg holds the FSM state enum and default constants for DEPTH and TIMEOUT.
REQ-037 FIFO storage, pointers and count live in sub-module sample_fifo; FSM and timers in adc_sample_ctrl.

Verification
REQ-038 enable=1, period=4, ADC model done 3 clocks after start, raw=1,2,3... -> adc_start pulses every 9 clocks, FIFO pops return 1,2,3 in order.
REQ-039 period=0 -> behaves identically to period=1.
REQ-040 No pops, DEPTH=8, 10 conversions -> fifo_count=8, overflow=1, pops return samples 1..8.
REQ-041 FIFO full, push and rd_en same clock -> count stays 8, overflow stays 0, head advances.
REQ-042 ADC model never asserts adc_done -> timeout_err=1 after 64 CONVERT clocks, FSM resumes, clr_err clears it.
REQ-043 reset pulsed low during CONVERT with 3 samples queued -> all outputs 0 immediately, adc_done next clock produces no push.
